// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic pipeline-stage register with a two-entry skid buffer.
// Moves a WIDTH-bit payload between stages using a valid/ready handshake.
// in_ready and out_valid come straight from flops, so out_ready has no
// combinational path to in_ready. A synchronous flush empties the stage.
// Optional feature macro: PIPE_SKID_PERF_EN adds the stall, bubble and flush
// counters. Without it the three counter ports are tied to zero.
module pipe_skid_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The state also serves as the occupancy of main and skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire, out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO);
    assign out_data  = main_data_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // State and payload registers. Reset takes priority over everything else.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Next state and payload moves. A flush empties the stage and leaves the payload registers unchanged.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire) begin
                        state_d     = TWO;
                        skid_data_d = in_data;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_q, bubble_q, flush_q;

    // Free-running event counters. They are cleared by reset only, not by flush, and wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (out_valid && !out_ready) stall_q  <= stall_q + 1'b1;
            if (!out_valid && out_ready) bubble_q <= bubble_q + 1'b1;
            if (flush)                   flush_q  <= flush_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised, elastic pipeline-stage register for the in-order core; the successor to the fixed-field, stall/kill-only inter-stage registers. Carries an opaque WIDTH-bit payload (decoded instruction fields, PC, immediates) between two stages with a full valid/ready handshake and a two-entry skid buffer. It sustains one transfer per cycle with no combinational ready path from consumer to producer, and supports a synchronous flush for branch/exception kill. Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB, with WIDTH set per boundary.

## Interface

- WIDTH, 32, payload width in bits (≥1)
- CNT_W, 32, width of performance counters (used only with PIPE_SKID_PERF_EN)

- clock  in  1  clock, all state updates on its rising edge
- reset  in  1  reset, synchronous, active-high
- flush  in  1  kill all held entries (branch taken / trap)
- in_valid  in  1  producer offers in_data
- in_ready  out  1  stage can accept; registered, depends only on state
- in_data  in  WIDTH  producer payload
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  WIDTH  payload, driven directly from the main register
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1
- flush_cnt  out  CNT_W  cycles in which flush=1

## Operation

- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d). States: EMPTY (neither valid), ONE (main only), TWO (main and skid).
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- out_valid = main_v; out_data = main_d; in_ready = !skid_v.
- Transitions when reset=0 and flush=0:
  - EMPTY: in_fire → ONE, main_d ← in_data. Otherwise stay in EMPTY.
  - ONE: out_fire & in_fire → ONE, main_d ← in_data. out_fire only → EMPTY. in_fire only → TWO, skid_d ← in_data. Neither → ONE.
  - TWO: in_ready=0. out_fire → ONE, main_d ← skid_d. Otherwise stay in TWO.
- Flush: next state EMPTY; main_v and skid_v ← 0. In a flush cycle:
  - an in-side offer is dropped, even if in_ready=1;
  - an out-side transfer that cycle counts as completed;
  - payload registers hold their values.
- Reset has priority over flush. Flush has priority over all handshakes.
- Order is strictly FIFO: skid never bypasses main. No payload is duplicated or lost except by flush.

## Timing

- Reset values: out_valid=0, in_ready=1, out_data=0, skid_d=0, all counters=0.
- Latency: 1 cycle. A payload accepted at edge N is visible on out_data after edge N.
- Throughput: 1 transfer per cycle in steady state while out_ready=1.
- in_ready deasserts the cycle after the stage enters TWO. It reasserts the cycle after the first out_fire in TWO.
- No combinational path from out_ready to in_ready, or from in_data to out_data.
- A producer holding in_valid with in_ready=0 must keep in_data stable. A consumer may drop out_ready at any time.
- Counters update on the same edge as the event they count, and wrap modulo 2^CNT_W.

## Configuration

- PIPE_SKID_PERF_EN defined: stall_cnt, bubble_cnt and flush_cnt are implemented as free-running counters, cleared only by reset (flush does not clear them).
- PIPE_SKID_PERF_EN undefined: no counter flops are synthesised, and the three counter ports are tied to 0. All other behaviour is identical.

## Test plan

- Streaming: in_valid=1 and out_ready=1 for 8 cycles with data 0x1..0x8 → out_data yields 0x1..0x8 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1.
- Backpressure: stream 0xA, 0xB, 0xC with out_ready=0 from the cycle 0xA appears → stage reaches TWO holding 0xA and 0xB; in_ready=0; 0xC is held by the producer. Release out_ready → outputs 0xA, 0xB, 0xC in order, with no loss or duplication.
- Flush in TWO: flush=1 for one cycle while in_valid=1 with 0xD → next cycle out_valid=0, in_ready=1, and 0xD is never output. With PIPE_SKID_PERF_EN, flush_cnt=1.
- Reset mid-stream: assert reset while in TWO with flush=1 → next cycle out_valid=0, out_data=0, in_ready=1, counters=0.
- Counters (PIPE_SKID_PERF_EN): 3 cycles with out_valid=1 and out_ready=0, then 2 cycles with EMPTY and out_ready=1 → stall_cnt=3, bubble_cnt=2. With the macro undefined, all counters read 0.
- Random valid/ready at 50% density for 10k cycles, scoreboarded against a reference FIFO → in-order delivery, no drops, in_ready never low in EMPTY or ONE.
